// File: rtl/sram_arbiter.sv
// sram_arbiter: multi-cycle controller for the single-port board SRAM shared
// by the instruction-fetch port and the memory-stage data port.
// One transfer at a time: IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
// All outputs are registered. Optional feature macro: SRAM_ARB_RR_EN
// (round-robin priority when both ports request; default is data-first).
module sram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2     // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,         // synchronous, active-low
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter value of the final ACCESS cycle.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic              own_data_q,   own_data_d;   // 1: data port owns the access
    logic              we_q,         we_d;         // latched write flag
    logic              prio_data_q,  prio_data_d;  // 1: data wins a tie
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic              sram_we_n_q,  sram_we_n_d;
    logic              sram_oe_n_q,  sram_oe_n_d;
    logic              i_ready_q,    i_ready_d;
    logic              d_ready_q,    d_ready_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              busy_q,       busy_d;
    logic              grant_data;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        own_data_d   = own_data_q;
        we_d         = we_q;
        prio_data_d  = prio_data_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        busy_d       = 1'b0;
        grant_data   = d_req & (~i_req | prio_data_q);

        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    state_d    = ACCESS;
                    cnt_d      = 4'd0;
                    busy_d     = 1'b1;
                    own_data_d = grant_data;
                    if (grant_data) begin
                        sram_addr_d  = d_addr;
                        sram_wdata_d = d_wdata;
                        we_d         = d_we;
                    end else begin
                        sram_addr_d  = i_addr;
                        we_d         = 1'b0;
                    end
                    sram_we_n_d = ~we_d;
                    sram_oe_n_d = we_d;
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    i_ready_d = ~own_data_q;
                    d_ready_d = own_data_q;
                    if (!we_q) begin
                        if (own_data_q) d_rdata_d = sram_rdata;
                        else            i_rdata_d = sram_rdata;
                    end
                end else begin
                    sram_we_n_d = ~we_q;
                    sram_oe_n_d = we_q;
                end
            end
            DONE: begin
                // Requests still high here are deliberately not re-granted.
                state_d = IDLE;
`ifdef SRAM_ARB_RR_EN
                prio_data_d = ~own_data_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            own_data_q   <= 1'b0;
            we_q         <= 1'b0;
            prio_data_q  <= 1'b1;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            own_data_q   <= own_data_d;
            we_q         <= we_d;
            prio_data_q  <= prio_data_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign i_ready    = i_ready_q;
    assign d_ready    = d_ready_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter.
// Main instance uses WAIT_CYCLES=2; a second instance uses WAIT_CYCLES=1.
// Directed table of single transfers, hand-written multi-cycle sequences,
// then randomized traffic checked against a transaction-level model.
module tb_sram_arbiter;

    localparam int W0 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [17:0] i_addr, d_addr;
    logic [31:0] d_wdata;
    logic [31:0] i_rdata, d_rdata, sram_wdata, sram_rdata;
    logic        i_ready, d_ready, sram_we_n, sram_oe_n, busy;
    logic [17:0] sram_addr;

    logic        i_req_1, d_req_1, d_we_1;
    logic [17:0] i_addr_1, d_addr_1;
    logic [31:0] d_wdata_1;
    logic [31:0] i_rdata_1, d_rdata_1, sram_wdata_1, sram_rdata_1;
    logic        i_ready_1, d_ready_1, sram_we_n_1, sram_oe_n_1, busy_1;
    logic [17:0] sram_addr_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .busy(busy)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req_1), .i_addr(i_addr_1), .i_rdata(i_rdata_1), .i_ready(i_ready_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_rdata(d_rdata_1), .d_ready(d_ready_1),
        .sram_addr(sram_addr_1), .sram_wdata(sram_wdata_1), .sram_rdata(sram_rdata_1),
        .sram_we_n(sram_we_n_1), .sram_oe_n(sram_oe_n_1), .busy(busy_1)
    );

    // Behavioural SRAM: unwritten words return a fixed address-derived pattern.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    logic [31:0] mem [0:255];
    bit   [255:0] written;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr[7:0]]     <= sram_wdata;
            written[sram_addr[7:0]] <= 1'b1;
        end
    end

    assign sram_rdata   = written[sram_addr[7:0]]   ? mem[sram_addr[7:0]]   : init_val(sram_addr[7:0]);
    assign sram_rdata_1 = written[sram_addr_1[7:0]] ? mem[sram_addr_1[7:0]] : init_val(sram_addr_1[7:0]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        d_req_1 = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Single transfer on the W0 instance, starting in IDLE at cycle 0.
    task automatic run_txn(input logic is_d, input logic we, input logic [17:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input string tag);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 1; c <= W0 + 1; c++) begin
            step();
            if (c <= W0) begin
                check({tag, " oe_n access"}, sram_oe_n, we);
                check({tag, " we_n access"}, sram_we_n, !we);
                check({tag, " addr access"}, sram_addr, addr);
                if (we) check({tag, " wdata access"}, sram_wdata, wdata);
                check({tag, " i_ready early"}, i_ready, 0);
                check({tag, " d_ready early"}, d_ready, 0);
                check({tag, " busy access"}, busy, 1);
            end else begin
                check({tag, " i_ready done"}, i_ready, !is_d);
                check({tag, " d_ready done"}, d_ready, is_d);
                check({tag, " we_n done"}, sram_we_n, 1);
                check({tag, " oe_n done"}, sram_oe_n, 1);
                check({tag, " addr done"}, sram_addr, addr);
                check({tag, " busy done"}, busy, 1);
                check({tag, " rdata"}, is_d ? d_rdata : i_rdata, exp_rdata);
            end
        end
        step();
        i_req = 1'b0; d_req = 1'b0;
        check({tag, " busy idle"}, busy, 0);
        check({tag, " ready idle"}, {30'd0, i_ready, d_ready}, 0);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // Random-test model state.
    logic [31:0] model_mem [0:15];
    bit          pend, pend_d, pend_we, pref_d, i_done_prev, d_done_prev;
    bit          got_i, got_d, take_d, allow;
    int          pend_cyc, next_free;
    logic [31:0] pend_data, exp_i_rd, exp_d_rd;
    logic [3:0]  idx;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req_1 = 1'b0; i_addr_1 = '0; d_req_1 = 1'b0; d_we_1 = 1'b0; d_addr_1 = '0; d_wdata_1 = '0;

        vecs[0] = '{1'b0, 1'b0, 18'h10, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 18'h20, 32'h12345678, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 18'h20, 32'h0,        32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 18'h20, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 18'h21, 32'hCAFEF00D, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 18'h21, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b0, 18'h05, 32'h0,        init_val(8'h05)};

        // Reset state.
        do_reset();
        check("rst i_ready", i_ready, 0);
        check("rst d_ready", d_ready, 0);
        check("rst i_rdata", i_rdata, 0);
        check("rst d_rdata", d_rdata, 0);
        check("rst sram_addr", sram_addr, 0);
        check("rst sram_wdata", sram_wdata, 0);
        check("rst pins", {30'd0, sram_we_n, sram_oe_n}, 3);
        check("rst busy", busy, 0);

        // Table of single transfers.
        for (int v = 0; v < 7; v++)
            run_txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                    vecs[v].exp_rdata, $sformatf("vec%0d", v));

        // Reset in the first ACCESS cycle of a write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 18'h22; d_wdata = 32'h11112222;
        step();
        check("abort we_n low", sram_we_n, 0);
        rst = 1'b0;
        step();
        check("abort we_n", sram_we_n, 1);
        check("abort oe_n", sram_oe_n, 1);
        check("abort busy", busy, 0);
        check("abort d_ready", d_ready, 0);
        rst = 1'b1; d_req = 1'b0;
        step();
        check("abort d_ready after", d_ready, 0);
        check("abort busy after", busy, 0);
        run_txn(1'b1, 1'b1, 18'h22, 32'h33334444, 32'h0, "rereq wr");
        run_txn(1'b1, 1'b0, 18'h22, 32'h0, 32'h33334444, "rereq rd");

        // Simultaneous requests: data first, instruction in the next slot.
        do_reset();
        check("sim c0 ready", {30'd0, i_ready, d_ready}, 0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 18'h30;
        i_req = 1'b1; i_addr = 18'h40;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("sim c%0d d_ready", c), d_ready, c == 3);
            check($sformatf("sim c%0d i_ready", c), i_ready, c == 7);
            if (c == 1 || c == 2) check($sformatf("sim c%0d addr", c), sram_addr, 18'h30);
            if (c == 5 || c == 6) check($sformatf("sim c%0d addr", c), sram_addr, 18'h40);
            if (c == 3) check("sim d_rdata", d_rdata, init_val(8'h30));
            if (c == 7) check("sim i_rdata", i_rdata, init_val(8'h40));
            if (c == 4) begin
                check("sim c4 oe_n", sram_oe_n, 1);
                d_req = 1'b0;
            end
            if (c == 8) i_req = 1'b0;
        end

        // Both requests held for 20 cycles.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bit exp_d, exp_i;
            if (c > 0) step();
`ifdef SRAM_ARB_RR_EN
            exp_d = (c == 3 || c == 11 || c == 19);
            exp_i = (c == 7 || c == 15);
`else
            exp_d = (c % 4 == 3);
            exp_i = 1'b0;
`endif
            check($sformatf("hold c%0d d_ready", c), d_ready, exp_d);
            check($sformatf("hold c%0d i_ready", c), i_ready, exp_i);
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 18'h50;
                i_req = 1'b1; i_addr = 18'h60;
            end
        end
        step();
        i_req = 1'b0; d_req = 1'b0;
        step();

        // WAIT_CYCLES=1 instance: back-to-back data reads.
        do_reset();
        d_req_1 = 1'b1; d_we_1 = 1'b0; d_addr_1 = 18'h1;
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("w1 c%0d d_ready", c), d_ready_1, c == 2 || c == 5);
            check($sformatf("w1 c%0d i_ready", c), i_ready_1, 0);
            if (c == 1) check("w1 c1 oe_n", sram_oe_n_1, 0);
            if (c == 2) begin
                check("w1 c2 oe_n", sram_oe_n_1, 1);
                check("w1 rdata 1", d_rdata_1, init_val(8'h01));
            end
            if (c == 3) d_addr_1 = 18'h2;
            if (c == 5) check("w1 rdata 2", d_rdata_1, init_val(8'h02));
            if (c == 6) d_req_1 = 1'b0;
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int a = 0; a < 16; a++) model_mem[a] = init_val(8'(8'h80 + a));
        pend = 1'b0; next_free = 0; pref_d = 1'b1;
        exp_i_rd = '0; exp_d_rd = '0;
        i_done_prev = 1'b0; d_done_prev = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) step();
            got_i = pend && (pend_cyc == cyc) && !pend_d;
            got_d = pend && (pend_cyc == cyc) && pend_d;
            check("rnd i_ready", i_ready, got_i);
            check("rnd d_ready", d_ready, got_d);
            check("rnd busy", busy, pend);
            if (got_i) exp_i_rd = pend_data;
            if (got_d && !pend_we) exp_d_rd = pend_data;
            if (got_i || got_d) begin
                check("rnd i_rdata", i_rdata, exp_i_rd);
                check("rnd d_rdata", d_rdata, exp_d_rd);
                pend = 1'b0;
            end

            allow = (cyc < 2980);
            if (i_done_prev || !i_req) begin
                i_req  = allow && ($urandom_range(0, 1) == 1);
                i_addr = 18'(8'h80 + $urandom_range(0, 15));
            end
            if (d_done_prev || !d_req) begin
                d_req   = allow && ($urandom_range(0, 1) == 1);
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = 18'(8'h80 + $urandom_range(0, 15));
                d_wdata = $urandom;
            end
            i_done_prev = got_i;
            d_done_prev = got_d;

            if (!pend && cyc >= next_free && (i_req || d_req)) begin
                take_d    = d_req && (!i_req || pref_d);
                pend      = 1'b1;
                pend_d    = take_d;
                pend_cyc  = cyc + W0 + 1;
                next_free = cyc + W0 + 2;
                if (take_d) begin
                    idx     = d_addr[3:0];
                    pend_we = d_we;
                    if (d_we) model_mem[idx] = d_wdata;
                    pend_data = model_mem[idx];
                end else begin
                    idx       = i_addr[3:0];
                    pend_we   = 1'b0;
                    pend_data = model_mem[idx];
                end
`ifdef SRAM_ARB_RR_EN
                pref_d = !take_d;
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Multi-cycle controller for the single-port board SRAM shared by the instruction-fetch stage and the memory stage of the 5-stage pipeline.
- Accepts one request at a time from each side and sequences the SRAM control pins over a fixed number of wait cycles.
- Returns a one-cycle ready pulse with read data; a low ready is the stall source for the requesting stage.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, SRAM access cycles per transfer. Legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_req  in  1  instruction read request; held until i_ready
- i_addr  in  ADDR_W  instruction word address
- i_rdata  out  DATA_W  instruction read data
- i_ready  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  data read data
- d_ready  out  1  one-cycle completion pulse, data port
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data
- sram_we_n  out  1  SRAM write enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- busy  out  1  high in ACCESS and DONE

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, counter=0.
  - i_ready=d_ready=0; i_rdata, d_rdata, sram_addr, sram_wdata = 0.
  - sram_we_n=sram_oe_n=1; busy=0; priority pointer → data.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high: grant per priority, latch addr/we/wdata into the owner registers, set counter=0, go to ACCESS.
  - Otherwise stay in IDLE.
- Fixed priority: data beats instruction. The memory stage is older, so serving it first cannot deadlock.
- ACCESS:
  - Lasts exactly WAIT_CYCLES cycles.
  - sram_addr and sram_wdata come from the latched registers and are stable throughout.
  - Read: sram_oe_n=0 for all ACCESS cycles. Write: sram_we_n=0 for all ACCESS cycles.
  - Counter increments each cycle. On the edge ending the cycle where counter==WAIT_CYCLES-1: on a read, sample sram_rdata into the owner's rdata register; go to DONE.
- DONE:
  - One cycle. Owner's ready=1; sram_we_n=sram_oe_n=1; address still held.
  - Next state is always IDLE, so a req still high in DONE is never re-granted.
  - The requester drops or changes req in the cycle after ready.
- Latency: req first sampled in IDLE at cycle 0 → ready high in cycle WAIT_CYCLES+1. Throughput is one transfer per WAIT_CYCLES+2 cycles.
- rdata registers hold their value until that port's next read completes. A write does not alter d_rdata.
- Ready outputs are registered and are never high on both ports in the same cycle.
- Inputs are ignored outside IDLE. Changing addr/wdata mid-access has no effect.
- Reset mid-operation: abort; next cycle is IDLE with pins deasserted. No ready is produced, and the partial write is the requester's concern.
- WAIT_CYCLES=1: ACCESS lasts a single cycle; rules otherwise unchanged.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: the priority pointer toggles to the other port after each completed grant (round-robin) and applies only when both reqs are high.
- Undefined: fixed data-first priority; the instruction port can starve while d_req is held high.

Test Plan:
- WAIT_CYCLES=2, instruction read: i_req=1, i_addr=0x10, sram_rdata=0xDEADBEEF → sram_oe_n low cycles 1-2, sram_addr=0x10, i_ready=1 only in cycle 3, i_rdata=0xDEADBEEF, d_ready stays 0.
- Data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 → sram_we_n low exactly cycles 1-2 with sram_addr=0x20 and sram_wdata=0x12345678; d_ready in cycle 3; d_rdata unchanged.
- Simultaneous requests at cycle 0 (data read 0x30, instruction 0x40) → data granted first, d_ready cycle 3; instruction granted in IDLE cycle 4, i_ready cycle 7 with sram_addr=0x40 in cycles 5-6.
- Reset during write: rst=0 in cycle 1 of ACCESS → next cycle state IDLE, sram_we_n=1, busy=0, no d_ready; re-request completes normally.
- Both reqs held high for 20 cycles → without SRAM_ARB_RR_EN: d_ready at cycles 3, 7, 11, 15, 19 and i_ready never; with it, d_ready at 3, 11, 19 and i_ready at 7, 15.
- WAIT_CYCLES=1, back-to-back data reads to 0x1, 0x2 → d_ready at cycles 2 and 5 with the matching rdata.
